// File: rtl/pdm_capture_cic_pkg.sv
// Shared types and helpers for the PDM capture / CIC decimator slice.
package pdm_pkg;

    localparam int unsigned PCM_MAX_WIDTH = 32;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } chan_t;

    // PCM is stored zero-extended; only the low DATA_WIDTH bits are meaningful.
    typedef struct packed {
        chan_t                    chan;
        logic [PCM_MAX_WIDTH-1:0] pcm;
    } fifo_entry_t;

    function automatic int unsigned cic_width(input int unsigned order, input int unsigned decim);
        return order * $clog2(decim) + 2;
    endfunction

endpackage

// File: rtl/pdm_capture_cic_if.sv
// PCM sample stream: head-of-FIFO sample with valid/ready handshake.
interface pdm_capture_cic_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic signed [DATA_WIDTH-1:0] pcm_data;
    logic                         pcm_chan;
    logic                         pcm_valid;
    logic                         pcm_ready;

    modport master (output pcm_data, pcm_chan, pcm_valid, input pcm_ready);
    modport slave  (input pcm_data, pcm_chan, pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_capture_cic_channel.sv
// One CIC decimation channel: integrators at the tick rate, combs at the
// decimated rate, then scaling with saturation and settle suppression.
module pdm_cic_channel
    import pdm_pkg::*;
#(
    parameter int unsigned DECIM      = 64,
    parameter int unsigned CIC_ORDER  = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         tick,
    input  logic                         dump,
    input  logic                         bit_in,
    output logic signed [DATA_WIDTH-1:0] pcm,
    output logic                         pcm_valid
);
    localparam int unsigned W     = cic_width(CIC_ORDER, DECIM);
    localparam int unsigned SHIFT = W - 1 - DATA_WIDTH;
    localparam int unsigned SW    = $clog2(CIC_ORDER + 1);

    typedef logic signed [W-1:0] acc_t;

    localparam acc_t PCM_MAX = acc_t'({{(SHIFT + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    localparam acc_t PCM_MIN = acc_t'({{(SHIFT + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}});

    acc_t                         integ    [CIC_ORDER];
    acc_t                         comb_dly [CIC_ORDER];
    acc_t                         comb_tap [CIC_ORDER];
    acc_t                         comb_acc;
    acc_t                         shifted;
    acc_t                         x_in;
    logic signed [DATA_WIDTH-1:0] sat_pcm;
    logic [SW-1:0]                settle_cnt;

    assign x_in = bit_in ? acc_t'(1) : '1;

    // Comb chain reads the last integrator before this tick's update.
    always_comb begin
        comb_acc = integ[CIC_ORDER-1];
        for (int unsigned k = 0; k < CIC_ORDER; k++) begin
            comb_tap[k] = comb_acc;
            comb_acc    = comb_acc - comb_dly[k];
        end
        shifted = comb_acc >>> SHIFT;
        if (shifted > PCM_MAX)
            sat_pcm = PCM_MAX[DATA_WIDTH-1:0];
        else if (shifted < PCM_MIN)
            sat_pcm = PCM_MIN[DATA_WIDTH-1:0];
        else
            sat_pcm = shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < CIC_ORDER; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
            end
            settle_cnt <= '0;
            pcm        <= '0;
            pcm_valid  <= 1'b0;
        end else if (clear) begin
            for (int unsigned k = 0; k < CIC_ORDER; k++) begin
                integ[k]    <= '0;
                comb_dly[k] <= '0;
            end
            settle_cnt <= '0;
            pcm_valid  <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (tick) begin
                integ[0] <= integ[0] + x_in;
                for (int unsigned k = 1; k < CIC_ORDER; k++)
                    integ[k] <= integ[k] + integ[k-1];
                if (dump) begin
                    for (int unsigned k = 0; k < CIC_ORDER; k++)
                        comb_dly[k] <= comb_tap[k];
                    if (settle_cnt == SW'(CIC_ORDER)) begin
                        pcm_valid <= 1'b1;
                        pcm       <= sat_pcm;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pdm_capture_cic.sv
// PDM microphone capture: clock divider, per-channel CIC decimation and an
// output FIFO with sticky overrun.
module pdm_capture_cic
    import pdm_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 32,
    parameter int unsigned DECIM      = 64,
    parameter int unsigned CIC_ORDER  = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned STEREO     = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    output logic                     pdm_clk,
    input  logic                     pdm_data,
    pdm_capture_cic_if.master        pcm,
    output logic                     overrun,
    input  logic                     clear_overrun
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned DEC_W = $clog2(DECIM);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt, div_next;
    logic [DEC_W-1:0] decim_cnt;
    logic             tick_l, tick_r, dump_l, dump_r, decim_adv, decim_last;

    always_comb div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

    // pdm_clk is registered from the next count so it tracks div_cnt exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pdm_clk <= (div_next < DIV_HALF);
        end
    end

    assign tick_l     = enable && (div_cnt == DIV_HALF_M1);
    assign tick_r     = (STEREO != 0) && enable && (div_cnt == DIV_LAST);
    assign decim_adv  = (STEREO != 0) ? tick_r : tick_l;
    assign decim_last = (decim_cnt == '1);
    assign dump_l     = tick_l && decim_last;
    assign dump_r     = tick_r && decim_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            decim_cnt <= '0;
        else if (!enable)
            decim_cnt <= '0;
        else if (decim_adv)
            decim_cnt <= decim_cnt + 1'b1;
    end

    logic signed [DATA_WIDTH-1:0] pcm_l, pcm_r;
    logic                         vld_l, vld_r;

    pdm_cic_channel #(
        .DECIM      (DECIM),
        .CIC_ORDER  (CIC_ORDER),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!enable),
        .tick      (tick_l),
        .dump      (dump_l),
        .bit_in    (pdm_data),
        .pcm       (pcm_l),
        .pcm_valid (vld_l)
    );

    generate
        if (STEREO != 0) begin : g_right
            pdm_cic_channel #(
                .DECIM      (DECIM),
                .CIC_ORDER  (CIC_ORDER),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_right (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (!enable),
                .tick      (tick_r),
                .dump      (dump_r),
                .bit_in    (pdm_data),
                .pcm       (pcm_r),
                .pcm_valid (vld_r)
            );
        end else begin : g_mono
            assign pcm_r = '0;
            assign vld_r = 1'b0;
        end
    endgenerate

    fifo_entry_t             mem [FIFO_DEPTH];
    fifo_entry_t             push_entry;
    logic [PTR_W:0]          wr_ptr, rd_ptr;
    logic                    empty, full, push_req, push_ok, pop, drop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = ((wr_ptr - rd_ptr) == (PTR_W + 1)'(FIFO_DEPTH));
    assign push_req = vld_l || vld_r;
    assign pop      = pcm.pcm_valid && pcm.pcm_ready;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_comb begin
        push_entry      = '0;
        push_entry.chan = vld_r ? RIGHT : LEFT;
        push_entry.pcm[DATA_WIDTH-1:0] = vld_r ? pcm_r : pcm_l;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

    assign pcm.pcm_valid = !empty;
    assign pcm.pcm_data  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]].pcm[DATA_WIDTH-1:0];
    assign pcm.pcm_chan  = empty ? 1'b0 : (mem[rd_ptr[PTR_W-1:0]].chan == RIGHT);

endmodule

// File: tb/tb_pdm_capture_cic.sv
// Self-checking bench for pdm_capture_cic: constant-level microphone model,
// random backpressure, and a DC-gain reference for expected PCM values.
module tb_pdm_capture_cic;

    localparam int unsigned CLK_DIV    = 32;
    localparam int unsigned DECIM      = 16;
    localparam int unsigned CIC_ORDER  = 4;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned SAMPLE_CYC = CLK_DIV * DECIM;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear_overrun = 1'b0;
    logic left_lvl = 1'b0;
    logic right_lvl = 1'b0;
    logic pdm_clk, pdm_data, overrun;

    int total = 0;
    int bad = 0;

    logic [DATA_WIDTH:0] got [$];

    pdm_capture_cic_if #(.DATA_WIDTH(DATA_WIDTH)) pcm_bus ();

    pdm_capture_cic #(
        .CLK_DIV    (CLK_DIV),
        .DECIM      (DECIM),
        .CIC_ORDER  (CIC_ORDER),
        .DATA_WIDTH (DATA_WIDTH),
        .STEREO     (1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pdm_clk       (pdm_clk),
        .pdm_data      (pdm_data),
        .pcm           (pcm_bus),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    // Stereo microphone pair: left drives while pdm_clk is high, right while low.
    assign pdm_data = pdm_clk ? left_lvl : right_lvl;

    always @(negedge clk)
        if (rst_n && pcm_bus.pcm_valid && pcm_bus.pcm_ready)
            got.push_back({pcm_bus.pcm_chan, pcm_bus.pcm_data});

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Constant +/-1 input settles to DC gain DECIM^ORDER, scaled and saturated.
    function automatic logic [DATA_WIDTH-1:0] model_pcm(input logic lvl);
        longint gain, v, lim;
        int unsigned w, shift;
        gain = 1;
        for (int unsigned i = 0; i < CIC_ORDER; i++) gain = gain * longint'(DECIM);
        w     = CIC_ORDER * $clog2(DECIM) + 2;
        shift = w - 1 - DATA_WIDTH;
        v     = lvl ? gain : -gain;
        v     = v >>> shift;
        lim   = longint'(1) << (DATA_WIDTH - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
        return v[DATA_WIDTH-1:0];
    endfunction

    task automatic cycles(input int n, input bit rand_ready);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) pcm_bus.pcm_ready = ($urandom_range(3) != 0);
        end
    endtask

    task automatic drain();
        pcm_bus.pcm_ready = 1'b1;
        for (int i = 0; i < 60 && pcm_bus.pcm_valid; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        pcm_bus.pcm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL reset_pdm_clk got=%b exp=0", pdm_clk); end
        total++; if (pcm_bus.pcm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pcm_bus.pcm_valid); end
        total++; if (pcm_bus.pcm_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", pcm_bus.pcm_data); end
        total++; if (pcm_bus.pcm_chan !== 1'b0) begin bad++; $display("FAIL reset_chan got=%b exp=0", pcm_bus.pcm_chan); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL idle_pdm_clk got=%b exp=0", pdm_clk); end
    endtask

    task automatic test_pdm_clk();
        logic s [150];
        int rises [$];
        int fall, highs;
        @(posedge clk);
        #1 enable = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            s[i] = pdm_clk;
        end
        for (int i = 1; i < 150; i++)
            if (s[i-1] === 1'b0 && s[i] === 1'b1) rises.push_back(i);
        total++;
        if (rises.size() < 4) begin
            bad++; $display("FAIL pdm_clk_edges got=%0d exp>=4", rises.size());
        end else begin
            total++; if (rises[2] - rises[1] != 32) begin bad++; $display("FAIL pdm_clk_period1 got=%0d exp=32", rises[2] - rises[1]); end
            total++; if (rises[3] - rises[2] != 32) begin bad++; $display("FAIL pdm_clk_period2 got=%0d exp=32", rises[3] - rises[2]); end
            fall = rises[1];
            while (fall < 149 && s[fall] === 1'b1) fall++;
            total++; if (fall - rises[1] != 16) begin bad++; $display("FAIL pdm_clk_high got=%0d exp=16", fall - rises[1]); end
        end
        @(posedge clk);
        #1 enable = 1'b0;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pdm_clk !== 1'b0) highs++;
        end
        total++; if (highs != 0) begin bad++; $display("FAIL pdm_clk_disabled got=%0d exp=0 high cycles", highs); end
    endtask

    task automatic test_levels(input logic l, input logic r, input int m);
        int exp_n;
        logic [DATA_WIDTH:0] exp_s;
        enable = 1'b0;
        cycles(4, 1'b0);
        got.delete();
        left_lvl  = l;
        right_lvl = r;
        enable    = 1'b1;
        cycles(m * SAMPLE_CYC + 100, 1'b1);
        enable = 1'b0;
        drain();
        exp_n = 2 * (m - int'(CIC_ORDER));
        if (exp_n < 0) exp_n = 0;
        total++; if (got.size() != exp_n) begin bad++; $display("FAIL level_count l=%b r=%b m=%0d got=%0d exp=%0d", l, r, m, got.size(), exp_n); end
        for (int i = 0; i < exp_n && i < got.size(); i++) begin
            exp_s = (i % 2 == 0) ? {1'b0, model_pcm(l)} : {1'b1, model_pcm(r)};
            total++; if (got[i] !== exp_s) begin bad++; $display("FAIL level_sample%0d got=%h exp=%h", i, got[i], exp_s); end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL level_overrun got=%b exp=0", overrun); end
        total++; if (pcm_bus.pcm_valid !== 1'b0) begin bad++; $display("FAIL level_drained got=%b exp=0", pcm_bus.pcm_valid); end
    endtask

    task automatic test_overrun();
        logic [DATA_WIDTH:0] head, exp_s;
        int unstable;
        enable = 1'b0;
        cycles(4, 1'b0);
        got.delete();
        left_lvl = 1'b1;
        right_lvl = 1'b0;
        pcm_bus.pcm_ready = 1'b0;
        enable = 1'b1;
        cycles((CIC_ORDER + 4) * SAMPLE_CYC + 60, 1'b0);
        total++; if (pcm_bus.pcm_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b exp=1", pcm_bus.pcm_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL full_no_overrun got=%b exp=0", overrun); end
        head = {pcm_bus.pcm_chan, pcm_bus.pcm_data};
        exp_s = {1'b0, model_pcm(1'b1)};
        total++; if (head !== exp_s) begin bad++; $display("FAIL full_head got=%h exp=%h", head, exp_s); end
        unstable = 0;
        for (int i = 0; i < int'(SAMPLE_CYC) + 60; i++) begin
            @(negedge clk);
            if (!pcm_bus.pcm_valid || {pcm_bus.pcm_chan, pcm_bus.pcm_data} !== head) unstable++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL hold_stable got=%0d exp=0 changed cycles", unstable); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        @(posedge clk);
        #1 enable = 1'b0;
        clear_overrun = 1'b1;
        @(posedge clk);
        #1 clear_overrun = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
        drain();
        total++; if (got.size() != FIFO_DEPTH) begin bad++; $display("FAIL overrun_count got=%0d exp=%0d", got.size(), FIFO_DEPTH); end
        for (int i = 0; i < int'(FIFO_DEPTH) && i < got.size(); i++) begin
            exp_s = (i % 2 == 0) ? {1'b0, model_pcm(1'b1)} : {1'b1, model_pcm(1'b0)};
            total++; if (got[i] !== exp_s) begin bad++; $display("FAIL overrun_entry%0d got=%h exp=%h", i, got[i], exp_s); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [DATA_WIDTH:0] exp_s;
        enable = 1'b0;
        cycles(4, 1'b0);
        left_lvl = 1'b1;
        right_lvl = 1'b1;
        pcm_bus.pcm_ready = 1'b0;
        enable = 1'b1;
        cycles((CIC_ORDER + 2) * SAMPLE_CYC - 8, 1'b0);
        total++; if (pcm_bus.pcm_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%b exp=1", pcm_bus.pcm_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (pcm_bus.pcm_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b exp=0", pcm_bus.pcm_valid); end
        total++; if (pcm_bus.pcm_data !== '0) begin bad++; $display("FAIL midreset_data got=%h exp=0", pcm_bus.pcm_data); end
        total++; if (pdm_clk !== 1'b0) begin bad++; $display("FAIL midreset_pdm_clk got=%b exp=0", pdm_clk); end
        left_lvl = 1'b0;
        right_lvl = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        pcm_bus.pcm_ready = 1'b1;
        cycles((CIC_ORDER + 1) * SAMPLE_CYC + 60, 1'b0);
        enable = 1'b0;
        drain();
        total++; if (got.size() != 2) begin bad++; $display("FAIL post_reset_count got=%0d exp=2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            exp_s = {i[0], model_pcm(1'b0)};
            total++; if (got[i] !== exp_s) begin bad++; $display("FAIL post_reset_sample%0d got=%h exp=%h", i, got[i], exp_s); end
        end
    endtask

    initial begin
        pcm_bus.pcm_ready = 1'b0;
        test_reset();
        test_pdm_clk();
        test_levels(1'b1, 1'b1, 6);
        test_levels(1'b0, 1'b0, 6);
        test_levels(1'b1, 1'b0, 6);
        test_levels(1'b0, 1'b1, int'(CIC_ORDER));
        test_levels(1'b1, 1'b0, int'(CIC_ORDER) + 1);
        for (int k = 0; k < 2; k++)
            test_levels(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(7, 5)));
        test_overrun();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
